// File: rtl/ex_operand_stage_pkg.sv
// ============================================================================
// ex_operand_stage_pkg : shared CPU constants for the EX operand stage
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package ex_operand_stage_pkg;

  localparam int CPU_DATA_W = 16;
  localparam int CPU_RA_W   = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_LHB = 3'b001,
    OP_SUB = 3'b010,
    OP_AND = 3'b011,
    OP_NOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_SRA = 3'b111
  } alu_op_e;

  // Field values loaded into ID/EX when a bubble is inserted
  localparam logic       NOP_VALID = 1'b0;
  localparam logic       NOP_WE    = 1'b0;
  localparam logic       NOP_ALUOP = 1'b0;
  localparam logic [2:0] NOP_CTRL  = OP_ADD;

endpackage

`default_nettype wire

// File: rtl/ex_operand_stage_fwd_mux.sv
// ============================================================================
// fwd_mux : per-operand forwarding selector (r0 -> 0, EX/MEM over MEM/WB)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module fwd_mux
  import ex_operand_stage_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int RA_W   = CPU_RA_W
) (
  input  logic [RA_W-1:0]   addr,
  input  logic [DATA_W-1:0] reg_val,
  input  logic              exmem_we,
  input  logic [RA_W-1:0]   exmem_rd_addr,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_we,
  input  logic [RA_W-1:0]   memwb_rd_addr,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] value
);

  always_comb begin
    value = reg_val;
    if (addr == '0) begin
      value = '0;
    end else if (exmem_we && (exmem_rd_addr == addr)) begin
      value = exmem_result;
    end else if (memwb_we && (memwb_rd_addr == addr)) begin
      value = memwb_result;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ex_operand_stage.sv
// ============================================================================
// ex_operand_stage : ID/EX register, operand forwarding and ALU flag register
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int RA_W   = CPU_RA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              bubble,
  input  logic              id_valid,
  input  logic [RA_W-1:0]   id_rs_addr,
  input  logic [RA_W-1:0]   id_rt_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [RA_W-1:0]   id_rd_addr,
  input  logic              id_we,
  input  logic [2:0]        id_ctrl,
  input  logic [3:0]        id_shamt,
  input  logic              id_aluOp,
  input  logic              id_use_imm,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              exmem_we,
  input  logic [RA_W-1:0]   exmem_rd_addr,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_we,
  input  logic [RA_W-1:0]   memwb_rd_addr,
  input  logic [DATA_W-1:0] memwb_result,
  input  logic              alu_ov,
  input  logic              alu_zr,
  input  logic              alu_ne,
  output logic [DATA_W-1:0] src0,
  output logic [DATA_W-1:0] src1,
  output logic [2:0]        ctrl,
  output logic [3:0]        shamt,
  output logic              aluOp,
  output logic              old_ov,
  output logic              old_zr,
  output logic              old_ne,
  output logic              ex_valid,
  output logic              ex_we,
  output logic [RA_W-1:0]   ex_rd_addr
);

  logic              valid_q,   valid_d;
  logic [RA_W-1:0]   rs_addr_q, rs_addr_d;
  logic [RA_W-1:0]   rt_addr_q, rt_addr_d;
  logic [DATA_W-1:0] rs_val_q,  rs_val_d;
  logic [DATA_W-1:0] rt_val_q,  rt_val_d;
  logic [RA_W-1:0]   rd_q,      rd_d;
  logic              we_q,      we_d;
  logic [2:0]        ctrl_q,    ctrl_d;
  logic [3:0]        shamt_q,   shamt_d;
  logic              aluop_q,   aluop_d;
  logic              use_imm_q, use_imm_d;
  logic [DATA_W-1:0] imm_q,     imm_d;
  logic              ov_q, ov_d, zr_q, zr_d, ne_q, ne_d;

  logic [DATA_W-1:0] rs_fwd, rt_fwd;
  logic [DATA_W-1:0] rs_cap, rt_cap;

  fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_rs (
    .addr(rs_addr_q), .reg_val(rs_val_q),
    .exmem_we(exmem_we), .exmem_rd_addr(exmem_rd_addr), .exmem_result(exmem_result),
    .memwb_we(memwb_we), .memwb_rd_addr(memwb_rd_addr), .memwb_result(memwb_result),
    .value(rs_fwd)
  );

  fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_rt (
    .addr(rt_addr_q), .reg_val(rt_val_q),
    .exmem_we(exmem_we), .exmem_rd_addr(exmem_rd_addr), .exmem_result(exmem_result),
    .memwb_we(memwb_we), .memwb_rd_addr(memwb_rd_addr), .memwb_result(memwb_result),
    .value(rt_fwd)
  );

  // The register file writes MEM/WB in this same cycle, so its read data is stale
  assign rs_cap = (memwb_we && (memwb_rd_addr == id_rs_addr) && (id_rs_addr != '0))
                ? memwb_result : id_rs_data;
  assign rt_cap = (memwb_we && (memwb_rd_addr == id_rt_addr) && (id_rt_addr != '0))
                ? memwb_result : id_rt_data;

  always_comb begin
    valid_d   = valid_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    rs_val_d  = rs_val_q;
    rt_val_d  = rt_val_q;
    rd_d      = rd_q;
    we_d      = we_q;
    ctrl_d    = ctrl_q;
    shamt_d   = shamt_q;
    aluop_d   = aluop_q;
    use_imm_d = use_imm_q;
    imm_d     = imm_q;
    ov_d      = ov_q;
    zr_d      = zr_q;
    ne_d      = ne_q;

    if (hold) begin
      // Latch forwarded values so a producer retiring during the stall is kept
      rs_val_d = rs_fwd;
      rt_val_d = rt_fwd;
    end else begin
      if (valid_q) begin
        ov_d = alu_ov;
        zr_d = alu_zr;
        ne_d = alu_ne;
      end
      if (bubble) begin
        valid_d   = NOP_VALID;
        rs_addr_d = '0;
        rt_addr_d = '0;
        rs_val_d  = '0;
        rt_val_d  = '0;
        rd_d      = '0;
        we_d      = NOP_WE;
        ctrl_d    = NOP_CTRL;
        shamt_d   = '0;
        aluop_d   = NOP_ALUOP;
        use_imm_d = 1'b0;
        imm_d     = '0;
      end else begin
        valid_d   = id_valid;
        rs_addr_d = id_rs_addr;
        rt_addr_d = id_rt_addr;
        rs_val_d  = rs_cap;
        rt_val_d  = rt_cap;
        rd_d      = id_rd_addr;
        we_d      = id_we;
        ctrl_d    = id_ctrl;
        shamt_d   = id_shamt;
        aluop_d   = id_aluOp;
        use_imm_d = id_use_imm;
        imm_d     = id_imm;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rs_val_q  <= '0;
      rt_val_q  <= '0;
      rd_q      <= '0;
      we_q      <= 1'b0;
      ctrl_q    <= '0;
      shamt_q   <= '0;
      aluop_q   <= 1'b0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      ov_q      <= 1'b0;
      zr_q      <= 1'b0;
      ne_q      <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      rs_val_q  <= rs_val_d;
      rt_val_q  <= rt_val_d;
      rd_q      <= rd_d;
      we_q      <= we_d;
      ctrl_q    <= ctrl_d;
      shamt_q   <= shamt_d;
      aluop_q   <= aluop_d;
      use_imm_q <= use_imm_d;
      imm_q     <= imm_d;
      ov_q      <= ov_d;
      zr_q      <= zr_d;
      ne_q      <= ne_d;
    end
  end

  assign src0       = rs_fwd;
  assign src1       = use_imm_q ? imm_q : rt_fwd;
  assign ctrl       = ctrl_q;
  assign shamt      = shamt_q;
  assign aluOp      = valid_q & aluop_q;
  assign ex_we      = valid_q & we_q;
  assign ex_valid   = valid_q;
  assign ex_rd_addr = rd_q;
  assign old_ov     = ov_q;
  assign old_zr     = zr_q;
  assign old_ne     = ne_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
// ============================================================================
// tb_ex_operand_stage : directed + randomized checks against a behavioural model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold, bubble, id_valid;
  logic [3:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic [15:0] id_rs_data, id_rt_data, id_imm;
  logic        id_we, id_aluOp, id_use_imm;
  logic [2:0]  id_ctrl;
  logic [3:0]  id_shamt;
  logic        exmem_we, memwb_we;
  logic [3:0]  exmem_rd_addr, memwb_rd_addr;
  logic [15:0] exmem_result, memwb_result;
  logic        alu_ov, alu_zr, alu_ne;
  logic [15:0] src0, src1;
  logic [2:0]  ctrl;
  logic [3:0]  shamt;
  logic        aluOp, old_ov, old_zr, old_ne, ex_valid, ex_we;
  logic [3:0]  ex_rd_addr;

  ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .bubble(bubble), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_rd_addr(id_rd_addr), .id_we(id_we), .id_ctrl(id_ctrl), .id_shamt(id_shamt),
    .id_aluOp(id_aluOp), .id_use_imm(id_use_imm), .id_imm(id_imm),
    .exmem_we(exmem_we), .exmem_rd_addr(exmem_rd_addr), .exmem_result(exmem_result),
    .memwb_we(memwb_we), .memwb_rd_addr(memwb_rd_addr), .memwb_result(memwb_result),
    .alu_ov(alu_ov), .alu_zr(alu_zr), .alu_ne(alu_ne),
    .src0(src0), .src1(src1), .ctrl(ctrl), .shamt(shamt), .aluOp(aluOp),
    .old_ov(old_ov), .old_zr(old_zr), .old_ne(old_ne),
    .ex_valid(ex_valid), .ex_we(ex_we), .ex_rd_addr(ex_rd_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, we, aluop, use_imm;
    logic [3:0]  rs, rt, rd, shamt;
    logic [15:0] rsv, rtv, imm;
    logic [2:0]  ctrl;
  } instr_t;

  instr_t     m, mn;
  logic [2:0] fl, fl_n;   // {ov, zr, ne}
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] fwd(input logic [3:0] a, input logic [15:0] v);
    if (a == 4'd0) return 16'h0000;
    if (exmem_we && exmem_rd_addr == a) return exmem_result;
    if (memwb_we && memwb_rd_addr == a) return memwb_result;
    return v;
  endfunction

  function automatic logic [15:0] captured(input logic [3:0] a, input logic [15:0] d);
    if (memwb_we && a != 4'd0 && memwb_rd_addr == a) return memwb_result;
    return d;
  endfunction

  task automatic model_reset();
    m  = '{default: '0};
    fl = 3'b000;
  endtask

  task automatic model_next();
    mn   = m;
    fl_n = fl;
    if (hold) begin
      mn.rsv = fwd(m.rs, m.rsv);
      mn.rtv = fwd(m.rt, m.rtv);
    end else begin
      if (m.valid) fl_n = {alu_ov, alu_zr, alu_ne};
      if (bubble) begin
        mn = '{default: '0};
      end else begin
        mn.valid = id_valid;   mn.we = id_we;       mn.aluop = id_aluOp;
        mn.use_imm = id_use_imm; mn.rs = id_rs_addr; mn.rt = id_rt_addr;
        mn.rd = id_rd_addr;    mn.shamt = id_shamt; mn.ctrl = id_ctrl;
        mn.imm = id_imm;
        mn.rsv = captured(id_rs_addr, id_rs_data);
        mn.rtv = captured(id_rt_addr, id_rt_data);
      end
    end
  endtask

  task automatic check_model();
    chk("ex_valid", 32'(ex_valid), 32'(m.valid));
    chk("aluOp",    32'(aluOp),    32'(m.valid & m.aluop));
    chk("ex_we",    32'(ex_we),    32'(m.valid & m.we));
    chk("flags",    32'({old_ov, old_zr, old_ne}), 32'(fl));
    if (m.valid) begin
      chk("src0",  32'(src0), 32'(fwd(m.rs, m.rsv)));
      chk("src1",  32'(src1), 32'(m.use_imm ? m.imm : fwd(m.rt, m.rtv)));
      chk("ctrl",  32'(ctrl),  32'(m.ctrl));
      chk("shamt", 32'(shamt), 32'(m.shamt));
      chk("rd",    32'(ex_rd_addr), 32'(m.rd));
    end
  endtask

  // Entered and left at posedge+1
  task automatic step();
    @(negedge clk);
    check_model();
    model_next();
    @(posedge clk);
    m  = mn;
    fl = fl_n;
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_flags", 32'({old_ov, old_zr, old_ne}), 32'd0);
    chk("rst_src", 32'({src0, src1}), 32'd0);
    chk("rst_misc", 32'({ctrl, shamt, aluOp, ex_we, ex_rd_addr}), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic idle();
    hold = 0; bubble = 0; id_valid = 0;
    id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_we = 0; id_aluOp = 0; id_use_imm = 0; id_ctrl = 0; id_shamt = 0;
    exmem_we = 0; exmem_rd_addr = 0; exmem_result = 0;
    memwb_we = 0; memwb_rd_addr = 0; memwb_result = 0;
    alu_ov = 0; alu_zr = 0; alu_ne = 0;
  endtask

  task automatic rand_inputs();
    hold       = ($urandom_range(0, 7) == 0);
    bubble     = ($urandom_range(0, 7) == 0);
    id_valid   = ($urandom_range(0, 3) != 0);
    id_rs_addr = 4'($urandom_range(0, 7));
    id_rt_addr = 4'($urandom_range(0, 7));
    id_rd_addr = 4'($urandom_range(0, 15));
    id_rs_data = 16'($urandom);
    id_rt_data = 16'($urandom);
    id_imm     = 16'($urandom);
    id_we      = 1'($urandom);
    id_aluOp   = 1'($urandom);
    id_use_imm = ($urandom_range(0, 3) == 0);
    id_ctrl    = 3'($urandom);
    id_shamt   = 4'($urandom);
    exmem_we      = 1'($urandom);
    exmem_rd_addr = 4'($urandom_range(0, 7));
    exmem_result  = 16'($urandom);
    memwb_we      = 1'($urandom);
    memwb_rd_addr = 4'($urandom_range(0, 7));
    memwb_result  = 16'($urandom);
    alu_ov = 1'($urandom); alu_zr = 1'($urandom); alu_ne = 1'($urandom);
  endtask

  task automatic issue(input logic [3:0] rs, input logic [15:0] rsd,
                       input logic [3:0] rt, input logic [15:0] rtd,
                       input logic [2:0] op);
    id_valid = 1; id_rs_addr = rs; id_rs_data = rsd;
    id_rt_addr = rt; id_rt_data = rtd; id_rd_addr = 4'd1;
    id_we = 1; id_aluOp = 1; id_ctrl = op; id_use_imm = 0;
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    model_reset();
    @(posedge clk); #1;

    // Reset with random inputs, then a first add
    rand_inputs();
    do_reset();
    idle();
    issue(4'd2, 16'h0003, 4'd3, 16'h0004, 3'b000);
    step();
    chk("add_src0", 32'(src0), 32'h0003);
    chk("add_src1", 32'(src1), 32'h0004);
    chk("add_valid", 32'(ex_valid), 32'd1);

    // Forwarding priority
    issue(4'd5, 16'h0000, 4'd5, 16'h0000, 3'b000);
    step();
    idle();
    exmem_we = 1; exmem_rd_addr = 4'd5; exmem_result = 16'h1111;
    memwb_we = 1; memwb_rd_addr = 4'd5; memwb_result = 16'h2222;
    #1 chk("fwd_exmem", 32'({src0, src1}), 32'h1111_1111);
    exmem_we = 0;
    #1 chk("fwd_memwb", 32'({src0, src1}), 32'h2222_2222);
    issue(4'd0, 16'h0055, 4'd0, 16'h0066, 3'b011);
    exmem_we = 1; exmem_rd_addr = 4'd0; memwb_we = 1; memwb_rd_addr = 4'd0;
    step();
    chk("fwd_r0", 32'({src0, src1}), 32'h0);

    // Hold retention of a MEM/WB producer
    idle();
    issue(4'd7, 16'h0000, 4'd2, 16'h0009, 3'b000);
    step();
    idle();
    hold = 1; memwb_we = 1; memwb_rd_addr = 4'd7; memwb_result = 16'h00AA;
    alu_ov = 1; alu_zr = 1; alu_ne = 1;
    step();
    memwb_we = 0;
    chk("hold_src0_1", 32'(src0), 32'h00AA);
    step();
    chk("hold_src0_2", 32'(src0), 32'h00AA);
    step();
    chk("hold_src0_3", 32'(src0), 32'h00AA);
    chk("hold_flags", 32'({old_ov, old_zr, old_ne}), 32'(fl));

    // Bubble commits the departing sub's flags
    idle();
    issue(4'd2, 16'h0001, 4'd3, 16'h0001, 3'b010);
    step();
    alu_ov = 1; alu_zr = 0; alu_ne = 0; bubble = 1; id_valid = 0;
    step();
    chk("bub_flags", 32'({old_ov, old_zr, old_ne}), 32'b100);
    chk("bub_valid", 32'(ex_valid), 32'd0);
    chk("bub_aluOp", 32'(aluOp), 32'd0);
    bubble = 0; alu_ov = 0; alu_zr = 1; alu_ne = 1;
    step();
    chk("bub_flags_kept", 32'({old_ov, old_zr, old_ne}), 32'b100);

    // Capture bypass from a same-cycle MEM/WB write
    idle();
    issue(4'd2, 16'h0001, 4'd4, 16'h0000, 3'b000);
    memwb_we = 1; memwb_rd_addr = 4'd4; memwb_result = 16'hBEEF;
    step();
    memwb_we = 0;
    #1 chk("cap_src1", 32'(src1), 32'hBEEF);

    // Hold beats bubble, then reset mid-hold
    idle();
    issue(4'd3, 16'h0123, 4'd0, 16'h0000, 3'b001);
    step();
    idle();
    hold = 1; bubble = 1;
    step();
    chk("hb_valid", 32'(ex_valid), 32'd1);
    chk("hb_src0", 32'(src0), 32'h0123);
    chk("hb_ctrl", 32'(ctrl), 32'd1);
    do_reset();
    idle();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      if ($urandom_range(0, 199) == 0) do_reset();
      else step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
